roadid_track_packer: RTL and testbench



---
 rtl/gf_packer_pkg.sv | 25 ++
 rtl/gf_pend_counter.sv | 28 ++
 rtl/roadid_track_packer.sv | 150 +++++++++++++++
 tb/tb_roadid_track_packer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_packer_pkg.sv
// Shared types and constants for the best-road track packer.
package gf_packer_pkg;

    localparam int WORD_W   = 32;
    localparam int ROADID_W = 21;
    localparam int ERR_W    = 2;

    localparam logic [2:0] HDR_TAG = 3'b001;
    localparam logic [2:0] EE_TAG  = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        HDR,
        PAR,
        EE
    } state_t;

    function automatic logic [WORD_W-1:0] make_header(input logic [ERR_W-1:0]    err,
                                                      input logic [ROADID_W-1:0] rid);
        return {HDR_TAG, err, 6'b0, rid};
    endfunction

endpackage

// File: rtl/gf_pend_counter.sv
// Pending-track up/down counter with saturation at max and a sticky overflow flag.
module gf_pend_counter #(
    parameter int CNT_W = 6
) (
    input  logic             CLOCK,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc && !dec) begin
            if (count == CNT_MAX) ovf <= 1'b1;
            else                  count <= count + CNT_W'(1);
        end else if (dec && !inc) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/roadid_track_packer.sv
// Serialises best-road tracks (header + NPAR parameter words) and end-event words onto a 32-bit stream.
// Optional ROADID_PACKER_PARITY_EN adds out_par, the XOR of out_data, registered alongside it.
module roadid_track_packer
    import gf_packer_pkg::*;
#(
    parameter int NPAR  = 4,
    parameter int CNT_W = 6
) (
    input  logic                   CLOCK,
    input  logic                   reset,
    input  logic                   trk_avail,
    input  logic [ROADID_W-1:0]    ROADID_IN,
    input  logic [ERR_W-1:0]       road_errors_in,
    input  logic [WORD_W*NPAR-1:0] par_in,
    output logic                   roadid_re,
    input  logic                   ee_in,
    output logic                   ee_ack,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_hold,
    output logic                   out_last,
    output logic                   cnt_ovf
`ifdef ROADID_PACKER_PARITY_EN
    ,
    output logic                   out_par
`endif
);

    localparam logic [2:0] LAST_IDX = 3'(NPAR - 1);

    state_t                   state, state_nxt;
    logic [2:0]               idx, idx_nxt;
    logic [15:0]              evt_cnt;
    logic [CNT_W-1:0]         count;
    logic [WORD_W*NPAR-1:0]   par_q;
    logic                     xfer;
    logic                     pending;
    logic [WORD_W-1:0]        data_nxt;
    logic                     valid_nxt;
    logic                     last_nxt;

    gf_pend_counter #(.CNT_W(CNT_W)) u_cnt (
        .CLOCK (CLOCK),
        .reset (reset),
        .inc   (trk_avail),
        .dec   (roadid_re),
        .count (count),
        .ovf   (cnt_ovf)
    );

    assign xfer = out_valid && !out_hold;
    // A pulse this cycle counts as pending so READ follows trk_avail by one cycle.
    assign pending = (count != '0) || trk_avail;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        roadid_re = 1'b0;
        ee_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (pending)    state_nxt = READ;
                else if (ee_in) state_nxt = EE;
            end
            READ: begin
                roadid_re = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: state_nxt = HDR;
            HDR: begin
                if (xfer) begin
                    state_nxt = PAR;
                    idx_nxt   = 3'd0;
                end
            end
            PAR: begin
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = pending ? READ : IDLE;
                        idx_nxt   = 3'd0;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            EE: begin
                if (xfer) begin
                    ee_ack    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output word for the coming cycle; a held word maps back onto itself.
    always_comb begin
        data_nxt  = '0;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        case (state_nxt)
            HDR: begin
                valid_nxt = 1'b1;
                data_nxt  = (state == WAIT) ? make_header(road_errors_in, ROADID_IN) : out_data;
            end
            PAR: begin
                valid_nxt = 1'b1;
                data_nxt  = par_q[WORD_W*int'(idx_nxt) +: WORD_W];
                last_nxt  = (idx_nxt == LAST_IDX);
            end
            EE: begin
                valid_nxt = 1'b1;
                data_nxt  = {EE_TAG, 13'b0, evt_cnt};
                last_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            evt_cnt   <= 16'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef ROADID_PACKER_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            out_last  <= last_nxt;
`ifdef ROADID_PACKER_PARITY_EN
            out_par   <= ^data_nxt;
`endif
            if (ee_ack) evt_cnt <= evt_cnt + 16'd1;
        end
    end

    // NOTE: par_q is pure datapath, always written before it is read, so it carries no reset.
    always_ff @(posedge CLOCK) begin
        if (state == WAIT) par_q <= par_in;
    end

endmodule

// File: tb/tb_roadid_track_packer.sv
// Directed bench for roadid_track_packer with FIFO model and output scoreboard.
module tb_roadid_track_packer;

    localparam int NPAR  = 4;
    localparam int CNT_W = 6;

    logic                 CLOCK = 1'b0;
    logic                 reset;
    logic                 trk_avail;
    logic [20:0]          ROADID_IN;
    logic [1:0]           road_errors_in;
    logic [32*NPAR-1:0]   par_in;
    logic                 roadid_re;
    logic                 ee_in;
    logic                 ee_ack;
    logic [31:0]          out_data;
    logic                 out_valid;
    logic                 out_hold;
    logic                 out_last;
    logic                 cnt_ovf;
`ifdef ROADID_PACKER_PARITY_EN
    logic                 out_par;
`endif

    always #5 CLOCK = ~CLOCK;

    roadid_track_packer #(.NPAR(NPAR), .CNT_W(CNT_W)) dut (
`ifdef ROADID_PACKER_PARITY_EN
        .out_par        (out_par),
`endif
        .CLOCK          (CLOCK),
        .reset          (reset),
        .trk_avail      (trk_avail),
        .ROADID_IN      (ROADID_IN),
        .road_errors_in (road_errors_in),
        .par_in         (par_in),
        .roadid_re      (roadid_re),
        .ee_in          (ee_in),
        .ee_ack         (ee_ack),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_hold       (out_hold),
        .out_last       (out_last),
        .cnt_ovf        (cnt_ovf)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct packed {
        logic [20:0]        rid;
        logic [1:0]         err;
        logic [32*NPAR-1:0] par;
    } trk_t;

    word_t exp_q[$];
    trk_t  fifo_q[$];
    trk_t  fifo_cur;
    word_t exp_cur;
    word_t held;
    logic  hold_seen = 1'b0;

    int checks  = 0;
    int errors  = 0;
    int re_cnt  = 0;
    int ack_cnt = 0;
    int xfer_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Non-FWFT FIFO model: dout updates on the edge that sees the read enable.
    always @(posedge CLOCK) begin
        if (!reset && roadid_re && fifo_q.size() != 0) begin
            fifo_cur = fifo_q.pop_front();
            ROADID_IN      <= fifo_cur.rid;
            road_errors_in <= fifo_cur.err;
            par_in         <= fifo_cur.par;
        end
    end

    // Scoreboard and handshake monitor, sampled mid-cycle.
    always @(negedge CLOCK) begin
        if (reset) begin
            hold_seen = 1'b0;
        end else begin
            if (roadid_re) begin
                re_cnt++;
                check("re_fifo_nonempty", 64'(fifo_q.size() != 0), 64'd1);
            end
            if (ee_ack) ack_cnt++;
            if (hold_seen) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_word", 64'({out_data, out_last}), 64'(held));
            end
            hold_seen = out_valid && out_hold;
            held      = {out_data, out_last};
            if (out_valid && !out_hold) begin
                xfer_cnt++;
                check("word_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_cur = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(exp_cur.data));
                    check("out_last", 64'(out_last), 64'(exp_cur.last));
`ifdef ROADID_PACKER_PARITY_EN
                    check("out_par", 64'(out_par), 64'(^exp_cur.data));
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic push_track(input logic [20:0] rid, input logic [1:0] err,
                              input logic [7:0] base, input bit expect_out);
        trk_t        t;
        logic [31:0] b;
        b     = {24'b0, base};
        t.rid = rid;
        t.err = err;
        for (int k = 0; k < NPAR; k++) t.par[32*k +: 32] = b + 32'(k);
        fifo_q.push_back(t);
        if (expect_out) begin
            exp_q.push_back({3'b001, err, 6'b0, rid, 1'b0});
            for (int k = 0; k < NPAR; k++) exp_q.push_back({b + 32'(k), k == NPAR - 1});
        end
        trk_avail = 1'b1;
        tick();
        trk_avail = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    task automatic end_event(input logic [15:0] evt, input int budget);
        int a0;
        a0    = ack_cnt;
        ee_in = 1'b1;
        exp_q.push_back({3'b011, 13'b0, evt, 1'b1});
        for (int i = 0; i < budget && ack_cnt == a0; i++) tick();
        ee_in = 1'b0;
        check("ee_ack_seen", 64'(ack_cnt - a0), 64'd1);
        wait_drain(10);
        repeat (3) tick();
        check("ee_ack_once", 64'(ack_cnt - a0), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"},  64'(out_data),  64'd0);
        check({tag, "_last"},  64'(out_last),  64'd0);
        check({tag, "_re"},    64'(roadid_re), 64'd0);
        check({tag, "_ack"},   64'(ee_ack),    64'd0);
        check({tag, "_ovf"},   64'(cnt_ovf),   64'd0);
        check({tag, "_count"}, 64'(dut.count), 64'd0);
`ifdef ROADID_PACKER_PARITY_EN
        check({tag, "_par"},   64'(out_par),   64'd0);
`endif
    endtask

    initial begin
        int r0, x0;
        reset     = 1'b1;
        trk_avail = 1'b0;
        ee_in     = 1'b0;
        out_hold  = 1'b0;
        #12;
        check_reset_outputs("rst");
        tick();
        reset = 1'b0;
        tick();

        // Single track, first-transaction latency
        push_track(21'h12345, 2'b01, 8'hA0, 1'b1);
        check("t1_re_cyc1", 64'(roadid_re), 64'd1);
        check("t1_count_cyc1", 64'(dut.count), 64'd1);
        tick();
        check("t1_re_cyc2", 64'(roadid_re), 64'd0);
        check("t1_valid_cyc2", 64'(out_valid), 64'd0);
        tick();
        check("t1_hdr_valid", 64'(out_valid), 64'd1);
        check("t1_hdr_data", 64'(out_data), 64'h2801_2345);
        wait_drain(20);
        check("t1_count_end", 64'(dut.count), 64'd0);

        // Three back-to-back tracks
        r0 = re_cnt;
        x0 = xfer_cnt;
        push_track(21'h00001,  2'b00, 8'h10, 1'b1);
        push_track(21'h1FFFFF, 2'b11, 8'h20, 1'b1);
        push_track(21'h0ABCD,  2'b10, 8'h30, 1'b1);
        wait_drain(60);
        check("b2b_re_count", 64'(re_cnt - r0), 64'd3);
        check("b2b_words", 64'(xfer_cnt - x0), 64'd15);
        check("b2b_count_end", 64'(dut.count), 64'd0);

        // Backpressure on the second parameter word
        x0 = xfer_cnt;
        push_track(21'h00777, 2'b01, 8'h40, 1'b1);
        repeat (4) tick();
        check("hold_par1_pre", 64'(out_data), 64'h41);
        out_hold = 1'b1;
        repeat (5) tick();
        check("hold_par1_post", 64'(out_data), 64'h41);
        check("hold_valid_post", 64'(out_valid), 64'd1);
        out_hold = 1'b0;
        wait_drain(20);
        check("hold_words", 64'(xfer_cnt - x0), 64'd5);

        // End of event behind two pending tracks, then a second event
        push_track(21'h0F0F0, 2'b00, 8'h50, 1'b1);
        push_track(21'h10101, 2'b11, 8'h58, 1'b1);
        end_event(16'h0000, 100);
        end_event(16'h0001, 50);

        // Simultaneous inc/dec, then saturation with the FSM stalled in HDR
        out_hold = 1'b1;
        push_track(21'h00001, 2'b00, 8'h70, 1'b0);
        trk_avail = 1'b1;
        check("simul_re", 64'(roadid_re), 64'd1);
        check("simul_count_pre", 64'(dut.count), 64'd1);
        tick();
        check("simul_count_post", 64'(dut.count), 64'd1);
        repeat (62) tick();
        check("sat_count_max", 64'(dut.count), 64'd63);
        check("sat_ovf_clear", 64'(cnt_ovf), 64'd0);
        tick();
        trk_avail = 1'b0;
        check("sat_count_hold", 64'(dut.count), 64'd63);
        check("sat_ovf_set", 64'(cnt_ovf), 64'd1);
        repeat (3) tick();
        check("sat_ovf_sticky", 64'(cnt_ovf), 64'd1);
        reset = 1'b1;
        #1;
        exp_q.delete();
        fifo_q.delete();
        out_hold = 1'b0;
        check_reset_outputs("ovf_rst");
        tick();
        reset = 1'b0;
        tick();

        // Asynchronous reset in the middle of PAR
        push_track(21'h2AAAA, 2'b10, 8'h60, 1'b1);
        repeat (4) tick();
        check("midpar_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        fifo_q.delete();
        check_reset_outputs("midpar_rst");
        tick();
        reset = 1'b0;
        tick();

        // Recovery: track plus end-event with the event counter back at zero
        push_track(21'h15555, 2'b01, 8'h80, 1'b1);
        end_event(16'h0000, 100);
        check("final_count", 64'(dut.count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
